pc_redirect_unit: RTL
=====================

Name: pc_redirect_unit

Overview:
- Program-counter register and next-PC selector for the fetch stage.
- Sits directly downstream of the word-offset shifter: it consumes the shifted branch offset and adds it to the branch's PC+4 to form the branch target.
- Also forms jump and jump-register targets, holds the PC on hazard stalls and instruction-memory waits, and buffers one redirect that arrives while fetch cannot advance.
- Drives the instruction-memory address and the IF/ID flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
PC_WIDTH, 32, width of PC and all address datapaths.

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  asynchronous, active-low reset
Stall  input  1  hazard-unit hold; PC must not advance
ImemReady  input  1  instruction memory accepted current address this cycle
BranchTaken  input  1  one-cycle pulse from ID: conditional branch resolved taken
Jump  input  1  one-cycle pulse from ID: J/JAL
JumpReg  input  1  one-cycle pulse from ID: JR/JALR
BranchPC4  input  32  PC+4 of the instruction in ID
BranchOffsetShifted  input  32  sign-extended offset shifted left by 2 (shifter output)
JumpIndex  input  26  instr[25:0] of the jump in ID
JumpRegAddr  input  32  rs value for JR/JALR
PC  output  32  current fetch address (to instruction memory)
PCPlus4  output  32  PC + 4 (to IF/ID register)
Flush  output  1  one-cycle pulse: squash IF/ID contents
RedirectPending  output  1  a buffered redirect is waiting to be applied
AddrErr  output  1  one-cycle pulse: JumpReg target not word-aligned

Behaviour:
- Reset (Rst=0, asynchronous):
  - PC=RESET_PC; PCPlus4=RESET_PC+4.
  - Flush=0, RedirectPending=0, AddrErr=0.
  - The pending target register is cleared to 0.
  - Reset mid-redirect discards any pending redirect.
- Advance condition: advance = ImemReady & ~Stall.
- Redirect request: req = JumpReg | BranchTaken | Jump.
- Target priority (combinational): JumpReg > BranchTaken > Jump.
  - JumpReg: {JumpRegAddr[31:2],2'b00}.
  - Branch: BranchPC4 + BranchOffsetShifted, modulo 2^32; wrap-around is silent.
  - Jump: {BranchPC4[31:28], JumpIndex, 2'b00}.
- Two states, encoded by RedirectPending:
  - IDLE (0):
    - advance & req: PC<=target, Flush<=1 next cycle, stay IDLE.
    - advance & ~req: PC<=PC+4.
    - ~advance & req: latch target, go PENDING, PC holds.
    - ~advance & ~req: PC holds.
  - PENDING (1):
    - advance: PC<=pending target, Flush<=1, go IDLE.
    - ~advance: hold.
    - Any new req while PENDING, including in the cycle that applies the pending target, is ignored; it is wrong-path and will be flushed.
- Flush:
  - Registered; high exactly one cycle after the PC is loaded with a redirect target, else 0.
  - A latch into PENDING does not raise Flush.
- AddrErr:
  - Registered one-cycle pulse when JumpReg is accepted (applied or latched) with JumpRegAddr[1:0]!=0.
  - The target is still forced word-aligned.
- PCPlus4 = PC+4, registered alongside PC so both update in the same edge. 0xFFFF_FFFC+4 wraps to 0.
- Latency:
  - Redirect accepted in cycle N appears on PC in cycle N+1, and Flush is high in cycle N+1.
  - A redirect from PENDING appears one cycle after the first advance cycle.

Decomposition:
- Shared package:
  - PC_WIDTH.
  - RESET_PC default.
  - Redirect-source encoding constants (SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_JR).
  - Instruction field widths (JUMP_INDEX_W=26).
- One natural sub-module: next_pc_select.
  - Purely combinational.
  - Implements target priority, the branch adder and jump concatenation.
  - Outputs target and the req flag.
- The top level holds PC, the pending register, Flush and AddrErr.

Test Plan:
1. Reset release with ImemReady=1, Stall=0, no requests for 4 cycles -> PC sequence 0x0,0x4,0x8,0xC,0x10; Flush=0 throughout.
2. BranchTaken pulse with BranchPC4=0x0000_0104 and BranchOffsetShifted=0xFFFF_FFF0 -> next PC=0x0000_00F4, Flush=1 for exactly that cycle; BranchOffsetShifted=0x0000_0020 -> PC=0x0000_0124.
3. ImemReady=0 when Jump pulses (BranchPC4=0x4000_0010, JumpIndex=0x0000_100) -> RedirectPending=1 and PC holds; ImemReady=1 two cycles later -> PC=0x4000_0400, Flush=1, RedirectPending=0.
4. While PENDING, a BranchTaken pulse arrives -> it is ignored; the PC takes the originally buffered target only.
5. JumpReg and BranchTaken in the same advance cycle, JumpRegAddr=0x0000_2003 -> PC=0x0000_2000, AddrErr pulses once, Flush=1.
6. Stall=1 for 3 cycles -> PC and PCPlus4 frozen; Rst asserted while PENDING -> PC=RESET_PC immediately, RedirectPending=0, and no Flush after release.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-stage PC register and next-PC selection.
// Holds address widths, the reset PC default and redirect-source encodings.
package pc_redirect_unit_pkg;

    localparam int                PC_WIDTH     = 32;
    localparam logic [31:0]       RESET_PC_DEF = 32'h0000_0000;
    localparam int                JUMP_INDEX_W = 26;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JUMP   = 2'd2,
        SRC_JR     = 2'd3
    } redirect_src_e;

    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational redirect-target selection: jump-register beats taken branch
// beats jump; also reports whether any redirect is requested and its source.
module next_pc_select #(
    parameter int PC_WIDTH = pc_redirect_unit_pkg::PC_WIDTH
) (
    input  logic                                          branch_taken,
    input  logic                                          jump,
    input  logic                                          jump_reg,
    input  logic [PC_WIDTH-1:0]                           branch_pc4,
    input  logic [PC_WIDTH-1:0]                           branch_offset_shifted,
    input  logic [pc_redirect_unit_pkg::JUMP_INDEX_W-1:0] jump_index,
    input  logic [PC_WIDTH-1:0]                           jump_reg_addr,
    output logic [PC_WIDTH-1:0]                           target,
    output logic                                          req,
    output pc_redirect_unit_pkg::redirect_src_e           src
);
    import pc_redirect_unit_pkg::*;

    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;

    // Branch target wraps silently modulo 2^PC_WIDTH.
    assign branch_target = branch_pc4 + branch_offset_shifted;
    assign jump_target   = {branch_pc4[PC_WIDTH-1:JUMP_INDEX_W+2], jump_index, 2'b00};
    assign req           = jump_reg | branch_taken | jump;

    always_comb begin
        target = branch_pc4;
        src    = SRC_SEQ;
        if (jump_reg) begin
            target = word_align(jump_reg_addr);
            src    = SRC_JR;
        end else if (branch_taken) begin
            target = branch_target;
            src    = SRC_BRANCH;
        end else if (jump) begin
            target = jump_target;
            src    = SRC_JUMP;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with sequential advance, immediate redirect, and a
// one-entry buffer for a redirect that arrives while fetch cannot advance.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = pc_redirect_unit_pkg::RESET_PC_DEF,
    parameter int          PC_WIDTH = pc_redirect_unit_pkg::PC_WIDTH
) (
    input  logic                                          Clk,
    input  logic                                          Rst,
    input  logic                                          Stall,
    input  logic                                          ImemReady,
    input  logic                                          BranchTaken,
    input  logic                                          Jump,
    input  logic                                          JumpReg,
    input  logic [PC_WIDTH-1:0]                           BranchPC4,
    input  logic [PC_WIDTH-1:0]                           BranchOffsetShifted,
    input  logic [pc_redirect_unit_pkg::JUMP_INDEX_W-1:0] JumpIndex,
    input  logic [PC_WIDTH-1:0]                           JumpRegAddr,
    output logic [PC_WIDTH-1:0]                           PC,
    output logic [PC_WIDTH-1:0]                           PCPlus4,
    output logic                                          Flush,
    output logic                                          RedirectPending,
    output logic                                          AddrErr
);
    import pc_redirect_unit_pkg::*;

    localparam logic [PC_WIDTH-1:0] FOUR = PC_WIDTH'(4);

    logic                advance;
    logic                req;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pend_target;
    redirect_src_e       src;
    logic                jr_misaligned;

    next_pc_select #(
        .PC_WIDTH(PC_WIDTH)
    ) u_sel (
        .branch_taken          (BranchTaken),
        .jump                  (Jump),
        .jump_reg              (JumpReg),
        .branch_pc4            (BranchPC4),
        .branch_offset_shifted (BranchOffsetShifted),
        .jump_index            (JumpIndex),
        .jump_reg_addr         (JumpRegAddr),
        .target                (target),
        .req                   (req),
        .src                   (src)
    );

    assign advance       = ImemReady & ~Stall;
    assign jr_misaligned = (src == SRC_JR) && (JumpRegAddr[1:0] != 2'b00);

    // RedirectPending doubles as the state bit: 0 = idle, 1 = target buffered.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            PC              <= PC_WIDTH'(RESET_PC);
            PCPlus4         <= PC_WIDTH'(RESET_PC) + FOUR;
            pend_target     <= '0;
            RedirectPending <= 1'b0;
            Flush           <= 1'b0;
            AddrErr         <= 1'b0;
        end else begin
            Flush   <= 1'b0;
            AddrErr <= 1'b0;
            if (RedirectPending) begin
                // Requests seen here are wrong-path and get squashed anyway.
                if (advance) begin
                    PC              <= pend_target;
                    PCPlus4         <= pend_target + FOUR;
                    Flush           <= 1'b1;
                    RedirectPending <= 1'b0;
                end
            end else if (req) begin
                AddrErr <= jr_misaligned;
                if (advance) begin
                    PC      <= target;
                    PCPlus4 <= target + FOUR;
                    Flush   <= 1'b1;
                end else begin
                    pend_target     <= target;
                    RedirectPending <= 1'b1;
                end
            end else if (advance) begin
                PC      <= PCPlus4;
                PCPlus4 <= PCPlus4 + FOUR;
            end
        end
    end

endmodule
